// File: rtl/vga_timing_rx.sv
// vga_timing_rx: receive-side VGA timing checker.
// Samples active-low hsync/vsync and 1-bit r/g/b through a two-flop
// synchronizer, measures line/frame timing on pix_ce, locks onto the
// configured mode and recovers active-region coordinates and pixel data.
// Ports:
//   clk, rst             system clock, asynchronous active-high reset
//   pix_ce               pixel-rate enable (one clk wide)
//   hsync_in, vsync_in   asynchronous active-low syncs
//   rgb_in               asynchronous pixel bits {r,g,b}
//   locked               timing matches the configured mode
//   de, x, y, rgb        active pixel valid, column, row, registered pixel
//   line_start           one-pix_ce pulse after hsync assertion
//   frame_start          one-pix_ce pulse after vsync assertion
//   h_period, v_lines    last measured line period / frame length
//   err_cnt              saturating count of lock losses
module vga_timing_rx #(
  parameter int H_TOTAL  = 800,
  parameter int H_SYNC   = 16,
  parameter int V_TOTAL  = 525,
  parameter int V_SYNC   = 1,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int V_BP     = 2,
  parameter int V_ACTIVE = 480,
  parameter int CW       = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_ce,
  input  logic          hsync_in,
  input  logic          vsync_in,
  input  logic [2:0]    rgb_in,
  output logic          locked,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic [2:0]    rgb,
  output logic          line_start,
  output logic          frame_start,
  output logic [CW-1:0] h_period,
  output logic [CW-1:0] v_lines,
  output logic [7:0]    err_cnt
);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  localparam logic [CW-1:0] CMAX   = '1;
  localparam logic [CW-1:0] HT     = CW'(H_TOTAL);
  localparam logic [CW-1:0] HS     = CW'(H_SYNC);
  localparam logic [CW-1:0] VT     = CW'(V_TOTAL);
  localparam logic [CW-1:0] VS     = CW'(V_SYNC);
  localparam logic [CW-1:0] TO     = CW'(2 * H_TOTAL);
  localparam logic [CW-1:0] HB     = CW'(H_BP);
  localparam logic [CW-1:0] HE     = CW'(H_BP + H_ACTIVE);
  localparam logic [CW-1:0] VB     = CW'(V_BP);
  localparam logic [CW-1:0] VE     = CW'(V_BP + V_ACTIVE);

  state_t        state, state_next;
  logic          err_inc;

  logic          h_s1, h_s2, v_s1, v_s2;
  logic [2:0]    rgb_s1, rgb_s2;
  logic          h_prev, v_prev;
  logic [CW-1:0] hcnt, vcnt, hwidth, vwidth;
  logic          vw_ok;

  logic          h_fall, h_rise, v_fall, v_rise;
  logic [CW-1:0] hcnt_inc, vcnt_inc, v_len;
  logic          line_bad, frame_ok, timeout, active;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_s1   <= 1'b1;
      h_s2   <= 1'b1;
      v_s1   <= 1'b1;
      v_s2   <= 1'b1;
      rgb_s1 <= '1;
      rgb_s2 <= '1;
    end else begin
      h_s1   <= hsync_in;
      h_s2   <= h_s1;
      v_s1   <= vsync_in;
      v_s2   <= v_s1;
      rgb_s1 <= rgb_in;
      rgb_s2 <= rgb_s1;
    end
  end

  // Edge flags are only meaningful on pix_ce cycles; every consumer is gated.
  assign h_fall   = h_prev & ~h_s2;
  assign h_rise   = ~h_prev & h_s2;
  assign v_fall   = v_prev & ~v_s2;
  assign v_rise   = ~v_prev & v_s2;

  assign hcnt_inc = (hcnt == CMAX) ? CMAX : hcnt + CW'(1);
  assign vcnt_inc = (vcnt == CMAX) ? CMAX : vcnt + CW'(1);
  // A coincident hsync edge belongs to the frame being closed.
  assign v_len    = h_fall ? vcnt_inc : vcnt;

  assign line_bad = (h_fall && hcnt_inc != HT) || (h_rise && hwidth != HS);
  assign frame_ok = (v_len == VT) && vw_ok;
  assign timeout  = !h_fall && (hcnt == TO);
  assign active   = (state == LOCKED) && (hcnt >= HB) && (hcnt < HE) &&
                    (vcnt >= VB) && (vcnt < VE);

  always_comb begin
    state_next = state;
    err_inc    = 1'b0;
    case (state)
      SEARCH: begin
        if (v_fall && !timeout) state_next = ACQUIRE;
      end
      ACQUIRE: begin
        if (line_bad || timeout)  state_next = SEARCH;
        else if (v_fall && frame_ok) state_next = LOCKED;
      end
      LOCKED: begin
        if (line_bad || timeout || (v_fall && !frame_ok)) begin
          state_next = SEARCH;
          err_inc    = 1'b1;
        end
      end
      default: state_next = SEARCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= SEARCH;
      err_cnt <= '0;
    end else if (pix_ce) begin
      state <= state_next;
      if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

  assign locked = (state == LOCKED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_prev      <= 1'b1;
      v_prev      <= 1'b1;
      hcnt        <= '0;
      vcnt        <= '0;
      hwidth      <= '0;
      vwidth      <= '0;
      vw_ok       <= 1'b0;
      h_period    <= '0;
      v_lines     <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      rgb         <= '0;
    end else if (pix_ce) begin
      h_prev <= h_s2;
      v_prev <= v_s2;

      if (h_fall) begin
        hcnt     <= '0;
        h_period <= hcnt_inc;
        hwidth   <= CW'(1);
      end else begin
        hcnt <= hcnt_inc;
        if (!h_s2 && hwidth != CMAX) hwidth <= hwidth + CW'(1);
      end

      if (v_fall) begin
        vcnt    <= '0;
        v_lines <= v_len;
        vwidth  <= h_fall ? CW'(1) : '0;
        vw_ok   <= 1'b0;
      end else begin
        if (h_fall) vcnt <= vcnt_inc;
        if (h_fall && !v_s2 && vwidth != CMAX) vwidth <= vwidth + CW'(1);
        if (v_rise) vw_ok <= (vwidth == VS);
      end

      line_start  <= h_fall;
      frame_start <= v_fall;

      de  <= active;
      x   <= active ? hcnt - HB : '0;
      y   <= active ? vcnt - VB : '0;
      rgb <= active ? rgb_s2 : '0;
    end
  end

endmodule

// File: tb/tb_vga_timing_rx.sv
module tb_vga_timing_rx;

  localparam int HT  = 40;
  localparam int HS  = 4;
  localparam int VT  = 12;
  localparam int VS  = 1;
  localparam int HBP = 6;
  localparam int HA  = 24;
  localparam int VBP = 2;
  localparam int VA  = 8;
  localparam int CW  = 8;

  logic          clk, rst, pix_ce, hsync_in, vsync_in;
  logic [2:0]    rgb_in;
  logic          locked, de, line_start, frame_start;
  logic [CW-1:0] x, y, h_period, v_lines;
  logic [2:0]    rgb;
  logic [7:0]    err_cnt;

  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic [2:0]    rgb;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   ls_cnt   = 0;
  int   fs_cnt   = 0;

  vga_timing_rx #(
    .H_TOTAL(HT), .H_SYNC(HS), .V_TOTAL(VT), .V_SYNC(VS),
    .H_BP(HBP), .H_ACTIVE(HA), .V_BP(VBP), .V_ACTIVE(VA), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .pix_ce(pix_ce),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .rgb_in(rgb_in),
    .locked(locked), .de(de), .x(x), .y(y), .rgb(rgb),
    .line_start(line_start), .frame_start(frame_start),
    .h_period(h_period), .v_lines(v_lines), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] pat(input int p, input int l);
    int t;
    t = p + 3 * l;
    return t[2:0];
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One pixel slot: data set, then a single-clk pix_ce pulse.
  task automatic pix(input logic h, input logic v, input logic [2:0] c);
    @(posedge clk); #1;
    hsync_in = h; vsync_in = v; rgb_in = c; pix_ce = 1'b0;
    @(posedge clk); #1;
    pix_ce = 1'b1;
    @(posedge clk); #1;
    pix_ce = 1'b0;
  endtask

  task automatic send_line(input int l, input int period, input int hw,
                           input bit vlow, input bit exp, input int npix);
    exp_t e;
    if (exp && l >= VBP && l < VBP + VA) begin
      for (int j = 0; j < HA; j++) begin
        e.x   = CW'(j);
        e.y   = CW'(l - VBP);
        e.rgb = pat(j + HBP + 1, l);
        sb.push_back(e);
      end
    end
    for (int p = 0; p < npix; p++)
      pix((p < hw) ? 1'b0 : 1'b1, vlow ? 1'b0 : 1'b1, pat(p, l));
  endtask

  task automatic send_frame(input bit exp, input int stretch, input int hw);
    int per;
    for (int l = 0; l < VT; l++) begin
      per = (l == stretch) ? HT + 1 : HT;
      send_line(l, per, hw, l < VS, exp, per);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_de"}, int'(de), 0);
    chk({tag, "_x"}, int'(x), 0);
    chk({tag, "_y"}, int'(y), 0);
    chk({tag, "_rgb"}, int'(rgb), 0);
    chk({tag, "_line_start"}, int'(line_start), 0);
    chk({tag, "_frame_start"}, int'(frame_start), 0);
    chk({tag, "_h_period"}, int'(h_period), 0);
    chk({tag, "_v_lines"}, int'(v_lines), 0);
    chk({tag, "_err_cnt"}, int'(err_cnt), 0);
  endtask

  // Monitor: after every pix_ce edge, pop and compare on de.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (pix_ce) begin
        #1;
        if (line_start)  ls_cnt++;
        if (frame_start) fs_cnt++;
        if (de) begin
          checks++;
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL pixel_unexpected: got de=1 x=%0d y=%0d expected de=0", x, y);
          end else begin
            e = sb.pop_front();
            if (x !== e.x || y !== e.y || rgb !== e.rgb) begin
              failures++;
              $display("FAIL pixel: got x=%0d y=%0d rgb=%0d expected x=%0d y=%0d rgb=%0d",
                       x, y, rgb, e.x, e.y, e.rgb);
            end
          end
        end
      end
    end
  end

  initial begin
    int fs0, ls0;
    rst = 1'b1; pix_ce = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1; rgb_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Partial frame, then reset in the middle of a line.
    send_line(6, HT, HS, 1'b0, 1'b0, HT);
    send_line(7, HT, HS, 1'b0, 1'b0, HT);
    send_line(8, HT, HS, 1'b0, 1'b0, 20);
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    for (int l = 9; l < VT; l++) send_line(l, HT, HS, 1'b0, 1'b0, HT);

    send_frame(1'b0, -1, HS);
    chk("f1_locked", int'(locked), 0);
    chk("f1_v_lines", int'(v_lines), 4);
    chk("f1_h_period", int'(h_period), HT);

    send_frame(1'b1, -1, HS);
    chk("f2_locked", int'(locked), 1);
    chk("f2_v_lines", int'(v_lines), VT);
    chk("f2_h_period", int'(h_period), HT);
    chk("f2_err_cnt", int'(err_cnt), 0);
    chk("f2_sb_empty", sb.size(), 0);

    // Line 0 stretched by one pixel.
    send_frame(1'b0, 0, HS);
    chk("stretch_locked", int'(locked), 0);
    chk("stretch_err_cnt", int'(err_cnt), 1);
    chk("stretch_h_period", int'(h_period), HT);
    send_frame(1'b0, -1, HS);
    chk("relock_acq_locked", int'(locked), 0);
    send_frame(1'b1, -1, HS);
    chk("relock_locked", int'(locked), 1);
    chk("relock_err_cnt", int'(err_cnt), 1);
    chk("relock_sb_empty", sb.size(), 0);

    // hsync stuck high: timeout, then saturated period on the next edge.
    for (int n = 0; n < 300; n++) pix(1'b1, 1'b1, 3'd0);
    chk("timeout_locked", int'(locked), 0);
    chk("timeout_err_cnt", int'(err_cnt), 2);
    send_line(0, HT, HS, 1'b1, 1'b0, HT);
    chk("sat_h_period", int'(h_period), 255);
    for (int l = 1; l < VT; l++) send_line(l, HT, HS, 1'b0, 1'b0, HT);
    chk("post_timeout_locked", int'(locked), 0);

    send_frame(1'b1, -1, HS);
    chk("pattern_locked", int'(locked), 1);
    chk("pattern_sb_empty", sb.size(), 0);

    // hsync one pixel too narrow: never locks, frames still detected.
    fs0 = fs_cnt; ls0 = ls_cnt;
    for (int f = 0; f < 3; f++) begin
      send_frame(1'b0, -1, HS - 1);
      chk("narrow_locked", int'(locked), 0);
    end
    chk("narrow_err_cnt", int'(err_cnt), 3);
    chk("narrow_frame_starts", fs_cnt - fs0, 3);
    chk("narrow_line_starts", ls_cnt - ls0, 3 * VT);

    send_frame(1'b0, -1, HS);
    send_frame(1'b1, -1, HS);
    chk("final_locked", int'(locked), 1);
    chk("final_sb_empty", sb.size(), 0);

    // Reset while de is high: outputs clear without a clock edge.
    for (int l = 0; l < 4; l++) send_line(l, HT, HS, l < VS, 1'b1, HT);
    send_line(4, HT, HS, 1'b0, 1'b1, 20);
    chk("de_before_rst", int'(de), 1);
    #2 rst = 1'b1;
    #1;
    chk_outputs_zero("async_rst");
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
